// File: rtl/stim_sequencer.sv
// rtl/stim_sequencer.sv - FIFO-fed stimulus sequencer that drives DUT control pins and records sampled q
module stim_sequencer #(
    parameter int DEPTH  = 4,
    parameter int HOLD_W = 8,
    parameter int TS_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_rst_n,
    input  logic              in_enable,
    input  logic              in_d,
    input  logic [HOLD_W-1:0] in_hold,
    output logic              dut_rst_n,
    output logic              dut_enable,
    output logic              dut_d,
    input  logic              dut_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TS_W-1:0]   out_ts,
    output logic              out_q,
    output logic              busy,
    output logic              done
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = HOLD_W + 3;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_SAMPLE,
        S_EMIT
    } state_t;

    logic [EW-1:0]     r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_live;

    state_t            r_state;
    logic [HOLD_W-1:0] r_cnt;
    logic [TS_W-1:0]   r_idx;
    logic              r_dut_rst_n;
    logic              r_dut_enable;
    logic              r_dut_d;
    logic              r_out_valid;
    logic              r_out_q;
    logic [TS_W-1:0]   r_out_ts;
    logic              r_done;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_launch_ok;
    logic              w_pop;
    logic [EW-1:0]     w_head;
    logic [HOLD_W-1:0] w_head_hold;
    logic [HOLD_W-1:0] w_hold_load;

    // in_ready stays low until the first edge after reset release
    assign w_full      = (r_count == FULL_CNT);
    assign w_empty     = (r_count == '0);
    assign in_ready    = r_live && !w_full;
    assign w_push      = in_valid && in_ready;
    assign w_launch_ok = run && !w_empty;
    assign w_pop       = w_launch_ok &&
                         ((r_state == S_IDLE) || ((r_state == S_EMIT) && out_ready));
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_hold = w_head[HOLD_W-1:0];
    assign w_hold_load = (w_head_hold == '0) ? HOLD_W'(1) : w_head_hold;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_rst_n, in_enable, in_d, in_hold};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_live   <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_dut_rst_n  <= 1'b0;
            r_dut_enable <= 1'b0;
            r_dut_d      <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_q      <= 1'b0;
            r_out_ts     <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: ;
                S_APPLY: begin
                    r_cnt <= r_cnt - HOLD_W'(1);
                    if (r_cnt == HOLD_W'(1)) begin
                        r_state <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    r_out_q     <= dut_q;
                    r_out_ts    <= r_idx;
                    r_out_valid <= 1'b1;
                    r_state     <= S_EMIT;
                end
                S_EMIT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_idx       <= r_idx + TS_W'(1);
                        if (!w_pop) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // A launch (from IDLE or straight out of EMIT) overrides the case above
            if (w_pop) begin
                r_state      <= S_APPLY;
                r_dut_rst_n  <= w_head[EW-1];
                r_dut_enable <= w_head[EW-2];
                r_dut_d      <= w_head[EW-3];
                r_cnt        <= w_hold_load;
            end
        end
    end

    assign dut_rst_n  = r_dut_rst_n;
    assign dut_enable = r_dut_enable;
    assign dut_d      = r_dut_d;
    assign out_valid  = r_out_valid;
    assign out_q      = r_out_q;
    assign out_ts     = r_out_ts;
    assign done       = r_done;
    assign busy       = (r_state != S_IDLE);

endmodule
